i2c_target_responder: RTL and testbench

- Synthesizable I2C target (responder) for the i2cmb bench; the opposite end from the iicmb_m_wb controller (initiator).
- Sits on one wand-resolved scl/sda bus line and answers one 7-bit address, backed by a small byte register file with an auto-incrementing pointer.
- Gives the bench an RTL target that it can check against the behavioural I2C slave BFM.

---
 rtl/i2c_target_responder.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// I2C target answering one 7-bit address, backed by a byte register file with an
// auto-incrementing pointer. Never stretches SCL; SDA is open-drain (1 = release).
module i2c_target_responder #(
    parameter logic [6:0] TGT_ADDR    = 7'h22,
    parameter int         MEM_AW      = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_o,
    output logic              sda_o,
    output logic              busy_o,
    output logic              wr_stb_o,
    output logic [MEM_AW-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              rd_stb_o
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    typedef struct packed {
        logic              en;
        logic [MEM_AW-1:0] addr;
        logic [7:0]        data;
    } wr_req_t;

    state_t                     state, state_nxt;
    logic [SYNC_STAGES-1:0]     scl_sync, sda_sync;
    logic                       scl_s, sda_s, scl_q, sda_q;
    logic                       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]                 cnt, cnt_nxt;
    logic [7:0]                 sh, sh_nxt, tx, tx_nxt, rx_byte;
    logic [MEM_AW-1:0]          ptr, ptr_nxt, ptr_inc;
    logic [DEPTH-1:0][7:0]      mem;
    logic                       sda_nxt, busy_nxt, rd_ld;
    wr_req_t                    wr_req;

    assign scl_o = 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & sda_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_q & sda_s;
    assign rx_byte   = {sh[6:0], sda_s};
    assign ptr_inc   = ptr + 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sda_nxt     = sda_o;
        busy_nxt    = busy_o;
        cnt_nxt     = cnt;
        sh_nxt      = sh;
        tx_nxt      = tx;
        ptr_nxt     = ptr;
        rd_ld       = 1'b0;
        wr_req.en   = 1'b0;
        wr_req.addr = ptr;
        wr_req.data = rx_byte;
        if (start_det) begin
            state_nxt = ADDR;
            cnt_nxt   = '0;
            sda_nxt   = 1'b1;
        end else if (stop_det) begin
            state_nxt = IDLE;
            sda_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: sda_nxt = 1'b1;
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        sh_nxt  = rx_byte;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_nxt = '0;
                            case (state)
                                ADDR: begin
                                    if (rx_byte[7:1] == TGT_ADDR) begin
                                        busy_nxt  = 1'b1;
                                        state_nxt = ADDR_ACK;
                                    end else begin
                                        state_nxt = IDLE;
                                    end
                                end
                                WR_PTR: begin
                                    ptr_nxt   = rx_byte[MEM_AW-1:0];
                                    state_nxt = WR_ACK;
                                end
                                default: begin
                                    wr_req.en = 1'b1;
                                    ptr_nxt   = ptr_inc;
                                    state_nxt = WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                // sda_o doubles as the ACK phase flag: released = ACK not yet driven
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (sda_o) begin
                            sda_nxt = 1'b0;
                        end else begin
                            sda_nxt = 1'b1;
                            if (state == WR_ACK) begin
                                state_nxt = WR_DATA;
                            end else if (!sh[0]) begin
                                state_nxt = WR_PTR;
                            end else begin
                                rd_ld     = 1'b1;
                                sda_nxt   = mem[ptr][7];
                                tx_nxt    = {mem[ptr][6:0], 1'b1};
                                cnt_nxt   = 4'd1;
                                state_nxt = RD_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_nxt   = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = RD_ACK;
                        end else begin
                            sda_nxt = tx[7];
                            tx_nxt  = {tx[6:0], 1'b1};
                            cnt_nxt = cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ptr_nxt = ptr_inc;
                        if (!sda_s) begin
                            // next byte is staged now but only driven after the following fall
                            rd_ld     = 1'b1;
                            tx_nxt    = mem[ptr_inc];
                            cnt_nxt   = '0;
                            state_nxt = RD_DATA;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sda_o     <= 1'b1;
            busy_o    <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
            tx        <= '1;
            ptr       <= '0;
            mem       <= '0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            rd_stb_o  <= 1'b0;
        end else begin
            sda_o    <= sda_nxt;
            busy_o   <= busy_nxt;
            cnt      <= cnt_nxt;
            sh       <= sh_nxt;
            tx       <= tx_nxt;
            ptr      <= ptr_nxt;
            wr_stb_o <= wr_req.en;
            rd_stb_o <= rd_ld;
            if (wr_req.en) begin
                mem[wr_req.addr] <= wr_req.data;
                wr_addr_o        <= wr_req.addr;
                wr_data_o        <= wr_req.data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-banged I2C controller on a wired-AND bus,
// a step table for whole transactions and hand sequences for abort/async reset.
module tb_i2c_target_responder;

    localparam int Q = 8;

    logic       clk_i = 1'b0, rst_i = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_i, sda_i, scl_o, sda_o, busy_o, wr_stb_o, rd_stb_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;

    int total = 0, bad = 0;
    int rd_cnt = 0, sda_low = 0, busy_hi = 0;
    bit watch = 0;
    logic [11:0] wr_q[$];
    logic [7:0]  rd_q[$];

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    always #5 clk_i = ~clk_i;

    i2c_target_responder #(.TGT_ADDR(7'h22), .MEM_AW(4), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
        .scl_o(scl_o), .sda_o(sda_o), .busy_o(busy_o),
        .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .rd_stb_o(rd_stb_o)
    );

    typedef enum {OP_S, OP_P, OP_WB, OP_RB, OP_BUSY, OP_WON, OP_WOFF, OP_END} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] d;
        logic [7:0] e;
        bit         w;
        logic [3:0] wa;
    } step_t;
    step_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (wr_stb_o) begin
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_stb unexpected: addr=%0d data=%0h want no strobe", wr_addr_o, wr_data_o);
                end else begin
                    logic [11:0] ex;
                    ex = wr_q.pop_front();
                    chk("wr_addr", wr_addr_o, ex[11:8]);
                    chk("wr_data", wr_data_o, ex[7:0]);
                end
            end
            if (rd_stb_o) rd_cnt++;
            if (watch && !sda_o) sda_low++;
            if (watch && busy_o) busy_hi++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    cyc(Q);
        scl_m = 1'b1; cyc(2 * Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        @(negedge clk_i);
        b = sda_i;
        cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    task automatic add(input op_e op, input logic [7:0] d, input logic [7:0] e,
                       input bit w, input logic [3:0] wa);
        step_t s;
        s.op = op; s.d = d; s.e = e; s.w = w; s.wa = wa;
        tbl.push_back(s);
    endtask

    task automatic run_step(input int idx, input step_t s);
        logic       a;
        logic [7:0] v;
        string      nm;
        nm = $sformatf("step%0d_%s", idx, s.op.name());
        case (s.op)
            OP_S:    bus_start();
            OP_P:    bus_stop();
            OP_WB: begin
                if (s.w) wr_q.push_back({s.wa, s.d});
                send_byte(s.d, a);
                chk({nm, "_ack"}, a, s.e[0]);
            end
            OP_RB: begin
                rd_q.push_back(s.e);
                recv_byte(s.d[0], v);
                chk({nm, "_data"}, v, rd_q.pop_front());
            end
            OP_BUSY: chk({nm, "_busy"}, busy_o, s.e[0]);
            OP_WON: begin
                watch = 1; sda_low = 0; busy_hi = 0;
            end
            OP_WOFF: begin
                watch = 0;
                chk({nm, "_sda_low_cycles"}, sda_low, 0);
                chk({nm, "_busy_cycles"}, busy_hi, 0);
            end
            OP_END: begin
                cyc(4);
                chk({nm, "_wr_pending"}, wr_q.size(), 0);
                chk({nm, "_rd_stb_count"}, rd_cnt, s.e);
                rd_cnt = 0;
            end
            default: ;
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic       a, b;
        logic [7:0] v;
        bit         seen;

        cyc(5);
        chk("rst_sda_o", sda_o, 1);
        chk("rst_scl_o", scl_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_stb", wr_stb_o, 0);
        chk("rst_rd_stb", rd_stb_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        rst_i = 1'b1;
        cyc(5);

        // seed mem[2]=77 and mem[6]=66 as sentinels for later checks
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h44, 0, 0, 0); add(OP_WB, 8'h02, 0, 0, 0);
        add(OP_WB, 8'h77, 0, 1, 4'd2); add(OP_P, 0, 0, 0, 0);
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h44, 0, 0, 0); add(OP_WB, 8'h06, 0, 0, 0);
        add(OP_WB, 8'h66, 0, 1, 4'd6); add(OP_P, 0, 0, 0, 0); add(OP_END, 0, 0, 0, 0);
        // write transaction
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h44, 0, 0, 0); add(OP_BUSY, 0, 1, 0, 0);
        add(OP_WB, 8'h03, 0, 0, 0); add(OP_WB, 8'hA5, 0, 1, 4'd3); add(OP_WB, 8'h5A, 0, 1, 4'd4);
        add(OP_P, 0, 0, 0, 0); add(OP_BUSY, 0, 0, 0, 0); add(OP_END, 0, 0, 0, 0);
        // pointer then repeated-start read
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h44, 0, 0, 0); add(OP_WB, 8'h03, 0, 0, 0);
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h45, 0, 0, 0);
        add(OP_RB, 0, 8'hA5, 0, 0); add(OP_RB, 0, 8'h5A, 0, 0); add(OP_RB, 1, 8'h00, 0, 0);
        add(OP_P, 0, 0, 0, 0); add(OP_BUSY, 0, 0, 0, 0); add(OP_END, 0, 3, 0, 0);
        // pointer should now be 6: plain read returns the sentinel
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h45, 0, 0, 0); add(OP_RB, 1, 8'h66, 0, 0);
        add(OP_P, 0, 0, 0, 0); add(OP_END, 0, 1, 0, 0);
        // wrong address
        add(OP_WON, 0, 0, 0, 0); add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h46, 1, 0, 0);
        add(OP_WB, 8'h11, 1, 0, 0); add(OP_P, 0, 0, 0, 0); add(OP_WOFF, 0, 0, 0, 0);
        add(OP_END, 0, 0, 0, 0);
        // wrap-around write and readback
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h44, 0, 0, 0); add(OP_WB, 8'h0F, 0, 0, 0);
        add(OP_WB, 8'h11, 0, 1, 4'd15); add(OP_WB, 8'h22, 0, 1, 4'd0);
        add(OP_P, 0, 0, 0, 0); add(OP_END, 0, 0, 0, 0);
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h44, 0, 0, 0); add(OP_WB, 8'h0F, 0, 0, 0);
        add(OP_S, 0, 0, 0, 0); add(OP_WB, 8'h45, 0, 0, 0);
        add(OP_RB, 0, 8'h11, 0, 0); add(OP_RB, 1, 8'h22, 0, 0);
        add(OP_P, 0, 0, 0, 0); add(OP_END, 0, 2, 0, 0);

        for (int i = 0; i < tbl.size(); i++) run_step(i, tbl[i]);

        // aborted data byte: STOP after 4 bits must not commit
        bus_start();
        send_byte(8'h44, a); chk("abort_addr_ack", a, 0);
        send_byte(8'h02, a); chk("abort_ptr_ack", a, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        cyc(4);
        chk("abort_busy", busy_o, 0);
        bus_start();
        send_byte(8'h44, a); send_byte(8'h02, a);
        bus_start();
        send_byte(8'h45, a); chk("abort_rd_ack", a, 0);
        rd_q.push_back(8'h77);
        recv_byte(1'b1, v);
        chk("abort_mem2", v, rd_q.pop_front());
        bus_stop();
        cyc(4);
        chk("abort_wr_pending", wr_q.size(), 0);
        rd_cnt = 0;

        // async reset while driving a 0 data bit (mem[3]=A5, bit6=0)
        bus_start();
        send_byte(8'h44, a); send_byte(8'h03, a);
        bus_start();
        send_byte(8'h45, a); chk("arst_addr_ack", a, 0);
        recv_bit(b); chk("arst_bit7", b, 1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (!sda_o) seen = 1;
            else cyc(1);
        end
        chk("arst_sda_driven_low", seen, 1);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_sda_released", sda_o, 1);
        chk("arst_busy_cleared", busy_o, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        cyc(4);
        rst_i = 1'b1;
        cyc(4);
        chk("arst_busy_after", busy_o, 0);
        rd_cnt = 0;
        bus_start();
        send_byte(8'h44, a); send_byte(8'h00, a);
        bus_start();
        send_byte(8'h45, a); chk("arst_rd_ack", a, 0);
        for (int i = 0; i < 16; i++) begin
            rd_q.push_back(8'h00);
            recv_byte((i == 15), v);
            chk($sformatf("arst_mem%0d", i), v, rd_q.pop_front());
        end
        bus_stop();
        cyc(4);
        chk("arst_rd_stb_count", rd_cnt, 16);
        chk("arst_busy_end", busy_o, 0);
        chk("arst_wr_pending", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
